// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with status flags and valid/ready handshakes.
// Single-cycle ops finish on the accept edge; MUL runs a WIDTH-step shift-add.
module alu_seq #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       alu_sel_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic             flag_z_o,
   output logic             flag_c_o,
   output logic             flag_v_o,
   output logic             flag_n_o,
   output logic             busy_o
);

   localparam int CNT_W = SHAMT_W + 1;
   localparam int MSB   = WIDTH - 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;

   logic             accept_s;
   logic             last_step_s;
   logic [WIDTH:0]   sum_s, diff_s, step_sum_s;
   logic [SHAMT_W-1:0] shamt_s;
   logic [WIDTH-1:0] alu_res_s;
   logic             alu_c_s, alu_v_s;
   logic [WIDTH-1:0] acc_step_s, mplr_step_s;

   assign accept_s    = in_valid_i & in_ready_o;
   assign last_step_s = (cnt_q == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               state_d = (alu_sel_i == OP_MUL) ? S_MUL : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: begin
            if (last_step_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_MUL;
            end
         end
         S_DONE: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held
   always_comb begin
      in_ready_o  = 1'b0;
      busy_o      = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         S_IDLE:  in_ready_o  = rst_n;
         S_MUL:   busy_o      = 1'b1;
         S_DONE:  out_valid_o = 1'b1;
         default: in_ready_o  = 1'b0;
      endcase
   end

   always_comb begin
      sum_s     = {1'b0, a_i} + {1'b0, b_i};
      diff_s    = {1'b0, a_i} - {1'b0, b_i};
      shamt_s   = b_i[SHAMT_W-1:0];
      alu_res_s = {WIDTH{1'b0}};
      alu_c_s   = 1'b0;
      alu_v_s   = 1'b0;
      case (alu_sel_i)
         OP_ADD: begin
            alu_res_s = sum_s[WIDTH-1:0];
            alu_c_s   = sum_s[WIDTH];
            alu_v_s   = (a_i[MSB] == b_i[MSB]) && (sum_s[MSB] != a_i[MSB]);
         end
         OP_SUB: begin
            alu_res_s = diff_s[WIDTH-1:0];
            alu_c_s   = diff_s[WIDTH];
            alu_v_s   = (a_i[MSB] != b_i[MSB]) && (diff_s[MSB] != a_i[MSB]);
         end
         OP_AND:  alu_res_s = a_i & b_i;
         OP_OR:   alu_res_s = a_i | b_i;
         OP_XOR:  alu_res_s = a_i ^ b_i;
         OP_SHL:  alu_res_s = a_i << shamt_s;
         OP_SHR:  alu_res_s = a_i >> shamt_s;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One multiply step: conditional add into the upper half, then shift the pair right
   always_comb begin
      step_sum_s  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
      acc_step_s  = step_sum_s[WIDTH:1];
      mplr_step_s = {step_sum_s[0], mplr_q[WIDTH-1:1]};
   end

   always_comb begin
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      res_hi_d = res_hi_q;
      z_d      = z_q;
      c_d      = c_q;
      v_d      = v_q;
      n_d      = n_q;
      if (accept_s) begin
         if (alu_sel_i == OP_MUL) begin
            mcand_d = a_i;
            mplr_d  = b_i;
            acc_d   = {WIDTH{1'b0}};
            cnt_d   = CNT_W'(WIDTH);
         end else begin
            res_d    = alu_res_s;
            res_hi_d = {WIDTH{1'b0}};
            z_d      = (alu_res_s == {WIDTH{1'b0}});
            c_d      = alu_c_s;
            v_d      = alu_v_s;
            n_d      = alu_res_s[MSB];
         end
      end else if (state_q == S_MUL) begin
         acc_d  = acc_step_s;
         mplr_d = mplr_step_s;
         cnt_d  = cnt_q - CNT_W'(1);
         if (last_step_s) begin
            res_d    = mplr_step_s;
            res_hi_d = acc_step_s;
            z_d      = ({acc_step_s, mplr_step_s} == {(2*WIDTH){1'b0}});
            c_d      = 1'b0;
            v_d      = 1'b0;
            n_d      = acc_step_s[MSB];
         end else begin
            res_d = res_q;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= {WIDTH{1'b0}};
         mplr_q   <= {WIDTH{1'b0}};
         acc_q    <= {WIDTH{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         res_q    <= {WIDTH{1'b0}};
         res_hi_q <= {WIDTH{1'b0}};
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
         n_q      <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         res_hi_q <= res_hi_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
         n_q      <= n_d;
      end
   end

   assign result_o    = res_q;
   assign result_hi_o = res_hi_q;
   assign flag_z_o    = z_q;
   assign flag_c_o    = c_q;
   assign flag_v_o    = v_q;
   assign flag_n_o    = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=8; expected results are
// queued when operands are sent and compared when the result is retired.
module tb_alu_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         z, c, v, n;
      logic [2:0]   op;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic [2:0]   sel_in = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result, result_hi;
   logic         fz, fc, fv, fn, busy;

   int total = 0;
   int bad = 0;
   exp_t sb[$];

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a_i(a_in), .b_i(b_in), .alu_sel_i(sel_in),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .result_o(result), .result_hi_o(result_hi),
      .flag_z_o(fz), .flag_c_o(fc), .flag_v_o(fv), .flag_n_o(fn),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      exp_t e;
      int sa, sb_i, si;
      logic [2*W-1:0] p;
      sa = $signed(a);
      sb_i = $signed(b);
      e.op = op;
      e.hi = '0;
      e.c = 1'b0;
      e.v = 1'b0;
      e.res = '0;
      case (op)
         3'd0: begin
            e.res = a + b;
            e.c = (int'(a) + int'(b)) > 255;
            si = sa + sb_i;
            e.v = (si > 127) || (si < -128);
         end
         3'd1: begin
            e.res = a - b;
            e.c = a < b;
            si = sa - sb_i;
            e.v = (si > 127) || (si < -128);
         end
         3'd2: e.res = a & b;
         3'd3: e.res = a | b;
         3'd4: e.res = a ^ b;
         3'd5: e.res = a << b[2:0];
         3'd6: e.res = a >> b[2:0];
         default: begin
            p = (2*W)'(a) * (2*W)'(b);
            e.res = p[W-1:0];
            e.hi = p[2*W-1:W];
         end
      endcase
      e.z = (e.res == '0) && (e.hi == '0);
      e.n = (op == 3'd7) ? e.hi[W-1] : e.res[W-1];
      return e;
   endfunction

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      int n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      check_eq("in_ready_before_send", 32'(in_ready), 32'd1);
      a_in = a;
      b_in = b;
      sel_in = op;
      in_valid = 1'b1;
      sb.push_back(model(a, b, op));
      tick();
      in_valid = 1'b0;
   endtask

   task automatic collect(input bit chk_lat);
      exp_t e;
      int lat = 1;
      int busy_n = 0;
      check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         while (!out_valid && lat < 40) begin
            if (busy) busy_n++;
            tick();
            lat++;
         end
         if (chk_lat) begin
            check_eq($sformatf("latency op%0d", e.op), 32'(lat), (e.op == 3'd7) ? 32'd9 : 32'd1);
            check_eq($sformatf("busy_cycles op%0d", e.op), 32'(busy_n), (e.op == 3'd7) ? 32'd8 : 32'd0);
         end
         check_eq("out_valid", 32'(out_valid), 32'd1);
         check_eq("in_ready_in_done", 32'(in_ready), 32'd0);
         check_eq($sformatf("result op%0d", e.op), 32'(result), 32'(e.res));
         check_eq($sformatf("result_hi op%0d", e.op), 32'(result_hi), 32'(e.hi));
         check_eq($sformatf("flags_zcvn op%0d", e.op), {28'd0, fz, fc, fv, fn}, {28'd0, e.z, e.c, e.v, e.n});
         out_ready = 1'b1;
         tick();
         check_eq("retired_valid", 32'(out_valid), 32'd0);
         check_eq("retired_in_ready", 32'(in_ready), 32'd1);
         check_eq("held_result", 32'(result), 32'(e.res));
      end
   endtask

   logic [W-1:0] da[10] = '{8'hFF, 8'h80, 8'h01, 8'h81, 8'h81, 8'hFF, 8'h00, 8'h7F, 8'hA5, 8'h0F};
   logic [W-1:0] db[10] = '{8'h01, 8'h01, 8'h02, 8'h0B, 8'h03, 8'hFF, 8'h37, 8'h01, 8'h5A, 8'h33};
   logic [2:0]   dop[10] = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd6, 3'd7, 3'd7, 3'd0, 3'd4, 3'd3};

   initial begin
      int seen;
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_outputs", {busy, out_valid, fz, fc, fv, fn, result_hi, result},
               32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         send(da[i], db[i], dop[i]);
         collect(1'b1);
      end

      for (int i = 0; i < 16; i++) begin
         send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
         collect(1'b1);
      end

      // backpressure with an ignored second operand
      out_ready = 1'b0;
      send(8'hF0, 8'h3C, 3'd2);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", 32'(out_valid), 32'd1);
         check_eq("bp_result", 32'(result), 32'h30);
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         a_in = 8'hFF;
         b_in = 8'h0F;
         sel_in = 3'd4;
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      collect(1'b0);
      seen = 0;
      repeat (4) begin
         if (out_valid) seen++;
         tick();
      end
      check_eq("bp_not_queued", 32'(seen), 32'd0);
      check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);

      // reset four cycles into a MUL
      send(8'hFF, 8'hFF, 3'd7);
      sb.delete();
      repeat (3) tick();
      check_eq("mid_mul_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_outputs", {busy, out_valid, fz, fc, fv, fn, result_hi, result}, 32'd0);
      check_eq("async_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (12) begin
         if (out_valid || busy) seen++;
         tick();
      end
      check_eq("post_rst_no_output", 32'(seen), 32'd0);
      send(8'h02, 8'h03, 3'd0);
      collect(1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 1-bit, 8-op combinational ALU.
- Operands are WIDTH bits wide. Every operation produces status flags.
- Operands are accepted and results are returned over valid/ready handshakes.
- MUL is a multi-cycle shift-add operation. The block sits between an operand sequencer and a result consumer on one clock domain.

Parameters:
- WIDTH, 8, operand/result width; a power of two, >= 2.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_sel  in  3  opcode.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result, low half for MUL.
- result_hi  out  WIDTH  high half of the MUL product; 0 for all other ops.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- flag_v  out  1  signed overflow flag.
- flag_n  out  1  negative flag.
- busy  out  1  MUL in progress.

Behaviour:
- Clock/reset (already decided): one clock, clk; rst_n is an asynchronous, active-low reset.
- Reset: state=IDLE. result, result_hi, all flags, out_valid and busy are 0. in_ready is 0 while rst_n is low.
- States:
  - IDLE: in_ready=1.
  - MUL: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: in_valid & in_ready on a rising edge latches a, b and alu_sel. In all other cycles inputs are ignored.
- Opcodes (unsigned unless noted):
  - 000 ADD: {c,result} = a+b.
  - 001 SUB: result = a-b; c = borrow (a<b).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a << b[SHAMT_W-1:0].
  - 110 SHR: logical, a >> b[SHAMT_W-1:0].
  - 111 MUL: {result_hi,result} = a*b, full 2*WIDTH product, no truncation.
- Flags:
  - z: result==0; for MUL, the entire 2*WIDTH product ==0.
  - n: MSB of result, or of result_hi for MUL.
  - v: two's-complement overflow for ADD/SUB only, else 0.
  - c: 0 for logic, shift and MUL ops.
- Single-cycle ops: accept edge goes IDLE->DONE. result and flags are registered on that edge, so out_valid rises one cycle after acceptance.
- MUL: accept edge goes IDLE->MUL, loading the multiplicand, multiplier and a counter of WIDTH.
  - Each cycle performs one shift-add step: add the multiplicand to the upper accumulator if the multiplier LSB is 1, then shift right.
  - After WIDTH steps the state goes MUL->DONE.
  - out_valid is first high WIDTH+1 cycles after the accept edge.
  - busy is high exactly WIDTH cycles.
- DONE: result, result_hi, flags and out_valid are held stable until out_valid & out_ready; then DONE->IDLE on that edge.
- No new operand is accepted in the same cycle as result retirement. Maximum throughput is one op per 2 cycles for single-cycle ops.
- Output registers keep their last values after retirement. Only out_valid deasserts.
- Reset asserted in any state: immediate return to reset values. Any in-flight MUL is discarded, with no partial result exposed.
- in_valid held high while in_ready=0 has no effect; the operation is not queued.

Test Plan:
- (WIDTH=8) ADD a=FF, b=01 -> out_valid 1 cycle after accept; result=00, z=1, c=1, v=0, n=0, result_hi=00.
- SUB a=80, b=01 -> result=7F, v=1, c=0, n=0, z=0. SUB a=01, b=02 -> result=FF, c=1, n=1, v=0.
- SHL a=81, b=0B (shamt 3) -> result=08. SHR a=81, b=03 -> result=10.
- MUL a=FF, b=FF -> busy high 8 cycles; out_valid exactly 9 cycles after accept; result_hi=FE, result=01, z=0, n=1. MUL a=00, b=37 -> z=1.
- Backpressure: AND a=F0, b=3C with out_ready=0 for 5 cycles -> result=30 held stable, in_ready=0. A second in_valid during this window is ignored. On out_ready=1 -> retire, IDLE next cycle.
- Reset mid-MUL: drop rst_n 4 cycles into MUL -> all outputs 0 asynchronously. After release, in_ready=1 and no out_valid appears. Then ADD 02+03 -> result=05.
